if_stage_skid_reg: RTL and testbench
====================================

# if_stage_skid_reg

Parametrised, elastic successor to the fetch/decode pipeline register. It carries a (PC, instruction) pair from IF to ID over a valid/ready handshake and buffers up to two entries, so `in_ready` has no combinational path from `out_ready`. It also supports freeze and flush with a configurable bubble instruction. It sits between the fetch unit and the decode stage.

## Interface
Parameters:
- `PC_W`, default 32: PC lane width.
- `INSTR_W`, default 32: instruction lane width.
- `NOP_INSTR`, default 32'hF000_0000, width `INSTR_W`: bubble instruction presented whenever the stage is empty.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: fetch offers an entry.
- `in_ready` out 1: stage can accept an entry.
- `in_pc` in `PC_W`: fetched PC.
- `in_instr` in `INSTR_W`: fetched instruction.
- `out_valid` out 1: entry presented to decode.
- `out_ready` in 1: decode consumes the entry.
- `out_pc` out `PC_W`: presented PC.
- `out_instr` out `INSTR_W`: presented instruction.
- `freeze` in 1: hold all contents; no transfers on either side.
- `flush` in 1: discard all contents.
- `occupancy` out 2: number of held entries (0–2).

## Operation
- Storage: a main entry (drives the outputs) and a skid entry, each holding PC and instruction. The state machine has three states: EMPTY, ONE, FULL.
- Transfer signals:
  - `accept = in_valid & in_ready`
  - `pop = out_valid & out_ready`
  - `in_ready = (state != FULL) & ~freeze & ~flush`
  - `out_valid = (state != EMPTY) & ~freeze & ~flush`
- Transitions (when neither flush nor freeze is active):
  - EMPTY: accept → ONE, main <= in.
  - ONE: accept & pop → ONE, main <= in. Accept only → FULL, skid <= in. Pop only → EMPTY.
  - FULL: pop → ONE, main <= skid. Accept cannot occur in FULL.
- Flush has priority over freeze. It is synchronous: next state is EMPTY, and both entries are loaded with pc=0, instr=`NOP_INSTR`. Nothing is accepted or popped in a flush cycle.
- Freeze (without flush): state and entries hold, and both handshakes are deasserted.
- When EMPTY: `out_pc`=0 and `out_instr`=`NOP_INSTR`. This also holds during freeze or flush while EMPTY.
- `occupancy` is 0, 1 or 2 for EMPTY, ONE, FULL respectively. It is registered and not masked by freeze.
- Data is never reordered, duplicated or dropped except by flush.

## Timing
- Reset values: state EMPTY; `out_valid`=0, `in_ready`=0 while `rst` is high, `out_pc`=0, `out_instr`=`NOP_INSTR`, `occupancy`=0.
- After reset release, `in_ready` goes to 1 in the same cycle, provided freeze and flush are low.
- Latency: an entry accepted at edge N is presented with `out_valid` high after edge N.
- Throughput: one entry per cycle while `out_ready` is held at 1.
- `in_ready` depends only on registered state, `freeze` and `flush`, never on `out_ready` or `in_valid`.
- A flush and an incoming valid in the same cycle: the input is not accepted. It must be re-presented after flush deasserts.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

## Structure
- Shared pipeline package holds:
  - the state enum (EMPTY/ONE/FULL);
  - the default `NOP_INSTR` constant, shared with the other stage registers;
  - an entry typedef {pc, instr}, sized by the package defaults.
- One sub-module, `pipe_entry_reg`: a parametrised entry register with load-enable and synchronous clear-to-bubble. It is instantiated twice, once for main and once for skid.

## Test plan
- Reset then idle: `out_valid`=0, `out_instr`=F000_0000, `out_pc`=0, `occupancy`=0, `in_ready`=1.
- Streaming: push PCs 0,4,8,12 back-to-back with `out_ready`=1 → same sequence out, one cycle later, one per cycle, `occupancy` stays 1.
- Backpressure: `out_ready`=0, push 0x100 then 0x104 → `occupancy`=2 and `in_ready`=0. Release `out_ready` → 0x100, then 0x104, then EMPTY.
- Freeze while FULL for 3 cycles with `out_ready`=1 → no pops, `out_valid`=0 and `in_ready`=0. After release, entries drain in order.
- Flush while FULL, together with `freeze`=1 and `in_valid`=1 (PC 0x200) → next cycle EMPTY, `out_instr`=F000_0000, and 0x200 is never output.
- Async reset asserted mid-clock while ONE → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/if_stage_skid_reg_pkg.sv
// Shared pipeline definitions for the IF/ID stage registers: fill-level
// states, the default bubble instruction and the default entry layout.
package if_stage_skid_reg_pkg;

  localparam int unsigned PIPE_PC_W    = 32;
  localparam int unsigned PIPE_INSTR_W = 32;

  // Bubble instruction injected whenever a stage register holds nothing.
  localparam logic [31:0] PIPE_NOP_INSTR = 32'hF000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_INSTR_W-1:0] instr;
  } pipe_entry_t;

  // Number of held entries for a given fill state.
  function automatic logic [1:0] state_to_occ(pipe_state_e s);
    logic [1:0] occ;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/if_stage_skid_reg_pipe_entry_reg.sv
// One (PC, instruction) storage slot with load-enable and a synchronous
// clear that turns the slot into a bubble (pc=0, instr=BUBBLE_INSTR).
// Data only: validity of the slot is tracked by the owner.
module pipe_entry_reg
  import if_stage_skid_reg_pkg::*;
#(
  parameter int unsigned            PC_W         = PIPE_PC_W,
  parameter int unsigned            INSTR_W      = PIPE_INSTR_W,
  parameter logic [INSTR_W-1:0]     BUBBLE_INSTR = INSTR_W'(PIPE_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Next contents: clear to bubble wins over a load, otherwise hold.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      pc_d    = '0;
      instr_d = BUBBLE_INSTR;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  // Storage flops; no reset, the owner masks the outputs while empty.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage_skid_reg.sv
// Elastic IF->ID pipeline register: two-entry skid buffer (main + skid)
// with valid/ready on both sides, freeze (hold) and flush (drop to
// bubble). in_ready is a function of registered state, freeze, flush and
// reset only, so there is no combinational path from out_ready.
module if_stage_skid_reg
  import if_stage_skid_reg_pkg::*;
#(
  parameter int unsigned        PC_W      = PIPE_PC_W,
  parameter int unsigned        INSTR_W   = PIPE_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               freeze,
  input  logic               flush,
  output logic [1:0]         occupancy
);

  pipe_state_e state_q, state_d;
  logic [1:0]  occ_q;

  logic accept, pop;
  logic main_load, skid_load, main_from_skid, clear_entries;

  logic [PC_W-1:0]    main_pc, skid_pc, main_pc_in;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_in;

  // Handshakes are masked by freeze and flush; in_ready also by reset.
  assign in_ready  = (state_q != ST_FULL)  & ~freeze & ~flush & ~rst;
  assign out_valid = (state_q != ST_EMPTY) & ~freeze & ~flush;
  assign accept    = in_valid  & in_ready;
  assign pop       = out_valid & out_ready;

  // Next fill state and slot load controls; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    clear_entries  = 1'b0;
    if (flush) begin
      state_d       = ST_EMPTY;
      clear_entries = 1'b1;
    end else if (!freeze) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Fill state and occupancy register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      occ_q   <= state_to_occ(state_d);
    end
  end

  // Main slot refills from the skid slot when draining FULL.
  assign main_pc_in    = main_from_skid ? skid_pc    : in_pc;
  assign main_instr_in = main_from_skid ? skid_instr : in_instr;

  pipe_entry_reg #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_main (
    .clk    (clk),
    .clear_i(clear_entries),
    .load_i (main_load),
    .pc_i   (main_pc_in),
    .instr_i(main_instr_in),
    .pc_o   (main_pc),
    .instr_o(main_instr)
  );

  pipe_entry_reg #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_skid (
    .clk    (clk),
    .clear_i(clear_entries),
    .load_i (skid_load),
    .pc_i   (in_pc),
    .instr_i(in_instr),
    .pc_o   (skid_pc),
    .instr_o(skid_instr)
  );

  // An empty stage always presents the bubble, whatever the slots hold.
  assign out_pc    = (state_q == ST_EMPTY) ? '0        : main_pc;
  assign out_instr = (state_q == ST_EMPTY) ? NOP_INSTR : main_instr;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// Bench for if_stage_skid_reg: a FIFO-queue model of the stage is checked
// against the DUT on every falling edge, plus directed literal checks.
module tb_if_stage_skid_reg;

  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        freeze, flush;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];       // model contents, head = presented entry
  logic [31:0] dut_log[$];  // PCs the DUT handed to decode

  if_stage_skid_reg #(
    .PC_W     (32),
    .INSTR_W  (32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .freeze   (freeze),
    .flush    (flush),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of at most two entries. Flush empties it; freeze holds
  // it; otherwise the head leaves when taken and a new entry joins when
  // there was room at the start of the cycle.
  always @(posedge clk or posedge rst) begin : model
    int n;
    if (rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else if (!freeze) begin
      n = mq.size();
      if (n > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && n < 2) mq.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : compare
    int   n;
    logic live;
    n    = mq.size();
    live = !rst && !freeze && !flush;
    chk("out_valid", {31'd0, out_valid}, {31'd0, (n > 0) && live});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, (n < 2) && live});
    chk("out_pc",    out_pc,    (n > 0) ? mq[0].pc    : 32'd0);
    chk("out_instr", out_instr, (n > 0) ? mq[0].instr : NOP);
    chk("occupancy", {30'd0, occupancy}, n[31:0]);
    if (out_valid && out_ready) dut_log.push_back(out_pc);
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(input string name, input logic [31:0] exp[$]);
    chk({name, "_len"}, dut_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < dut_log.size(); k++)
      chk(name, dut_log[k], exp[k]);
    dut_log.delete();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] exp_q[$];
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
    step(2);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'hF000_0000);
    rst = 1'b0;
    #1;
    chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_out_pc",    out_pc,             32'd0);
    chk("idle_out_instr", out_instr,          32'hF000_0000);
    chk("idle_occ",       {30'd0, occupancy}, 32'd0);
    step(1);

    // Streaming: 0,4,8,12 back to back with decode always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc    = 32'(i * 4);
      in_instr = 32'h0000_1000 + 32'(i);
      step(1);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
      chk("stream_pc",  out_pc, 32'(i * 4));
    end
    in_valid = 1'b0;
    step(2);
    exp_q = '{32'd0, 32'd4, 32'd8, 32'd12};
    check_log("stream_log", exp_q);

    // Backpressure: two entries fill the stage; a third is refused.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hA100;
    step(1);
    in_pc = 32'h104; in_instr = 32'hA104;
    step(1);
    chk("bp_occ",      {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready},  32'd0);
    in_pc = 32'h108; in_instr = 32'hA108;
    step(1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(3);
    chk("bp_empty", {30'd0, occupancy}, 32'd0);
    exp_q = '{32'h100, 32'h104};
    check_log("bp_log", exp_q);

    // Freeze while FULL: nothing moves, occupancy still visible.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hA300;
    step(1);
    in_pc = 32'h304; in_instr = 32'hA304;
    step(1);
    in_valid = 1'b0;
    freeze = 1'b1; out_ready = 1'b1;
    step(3);
    chk("frz_out_valid", {31'd0, out_valid}, 32'd0);
    chk("frz_in_ready",  {31'd0, in_ready},  32'd0);
    chk("frz_occ",       {30'd0, occupancy}, 32'd2);
    chk("frz_log_len",   dut_log.size(),     32'd0);
    freeze = 1'b0;
    step(3);
    exp_q = '{32'h300, 32'h304};
    check_log("frz_log", exp_q);

    // Flush while FULL with freeze and an incoming 0x200.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'hA400;
    step(1);
    in_pc = 32'h404; in_instr = 32'hA404;
    step(1);
    flush = 1'b1; freeze = 1'b1; in_pc = 32'h200; in_instr = 32'hA200;
    #2;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step(1);
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_occ",       {30'd0, occupancy}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_out_instr", out_instr,          32'hF000_0000);
    out_ready = 1'b1;
    step(3);
    exp_q = '{};
    check_log("fl_log", exp_q);

    // Asynchronous reset in the middle of a cycle while ONE.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'hA500;
    step(1);
    in_valid = 1'b0;
    #1;
    chk("ar_pre_occ", {30'd0, occupancy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'd0, in_ready},  32'd0);
    chk("ar_out_pc",    out_pc,             32'd0);
    chk("ar_out_instr", out_instr,          32'hF000_0000);
    chk("ar_occ",       {30'd0, occupancy}, 32'd0);
    step(2);
    rst = 1'b0;
    #1;
    chk("ar_rel_in_ready", {31'd0, in_ready}, 32'd1);
    step(2);
    dut_log.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
